// File: rtl/ia_compressor.sv
// Dense-to-sparse input-activation compressor: packs the nonzero channels of
// one pixel vector into (data, c_idx, len) slots and holds them for the PE loader.
module ia_compressor_slot #(
    parameter int DW  = 16,
    parameter int CW  = 5,
    parameter int LW  = 6,
    parameter int IDX = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] data,
    input  logic [CW-1:0] ch,
    output logic [DW-1:0] slot_data,
    output logic [CW-1:0] slot_c
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_data <= '0;
            slot_c    <= '0;
        end else if (clr) begin
            slot_data <= '0;
            slot_c    <= '0;
        end else if (wr && len == LW'(IDX)) begin
            slot_data <= data;
            slot_c    <= ch;
        end
    end
endmodule

module ia_compressor #(
    parameter int IA_CHANNEL       = 32,
    parameter int IA_DATA_BITWIDTH = 16,
    parameter int IA_C_BITWIDTH    = 5,
    localparam int LEN_W           = $clog2(IA_CHANNEL) + 1
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst_n,
    input  logic                                                i_in_valid,
    output logic                                                o_in_ready,
    input  logic signed [IA_DATA_BITWIDTH-1:0]                  i_in_data,
    input  logic                                                i_in_last,
    output logic                                                o_valid,
    input  logic                                                i_ready,
    output logic signed [IA_CHANNEL-1:0][IA_DATA_BITWIDTH-1:0]  o_ia_data,
    output logic [IA_CHANNEL-1:0][IA_C_BITWIDTH-1:0]            o_ia_c_idx,
    output logic [LEN_W-1:0]                                    o_ia_len
);
    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t                   state;
    logic [IA_C_BITWIDTH-1:0] ch;
    logic [LEN_W-1:0]         len;
    logic                     accept, nz, end_vec, handshake;

    assign accept    = i_in_valid && (state == COLLECT);
    assign nz        = (i_in_data != '0);
    assign end_vec   = accept && (i_in_last || ch == IA_C_BITWIDTH'(IA_CHANNEL - 1));
    assign handshake = (state == HOLD) && i_ready;

    assign o_in_ready = (state == COLLECT);
    assign o_valid    = (state == HOLD);
    assign o_ia_len   = len;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= COLLECT;
            ch    <= '0;
            len   <= '0;
        end else begin
            case (state)
                COLLECT: if (accept) begin
                    ch <= ch + IA_C_BITWIDTH'(1);
                    if (nz) len <= len + LEN_W'(1);
                    if (end_vec) state <= HOLD;
                end
                HOLD: if (handshake) begin
                    state <= COLLECT;
                    ch    <= '0;
                    len   <= '0;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Each slot latches only when the running len points at it, so packing is implicit.
    for (genvar i = 0; i < IA_CHANNEL; i++) begin : g_slot
        ia_compressor_slot #(
            .DW (IA_DATA_BITWIDTH),
            .CW (IA_C_BITWIDTH),
            .LW (LEN_W),
            .IDX(i)
        ) u_slot (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .clr      (handshake),
            .wr       (accept && nz),
            .len      (len),
            .data     (i_in_data),
            .ch       (ch),
            .slot_data(o_ia_data[i]),
            .slot_c   (o_ia_c_idx[i])
        );
    end
endmodule

// File: tb/tb_ia_compressor.sv
// Randomized and directed bench for ia_compressor with an 8-channel vector
// and a queue-based packing reference model.
module tb_ia_compressor;
    localparam int CH = 8;
    localparam int DW = 16;
    localparam int CW = 3;
    localparam int LW = 4;

    typedef logic signed [DW-1:0] beat_t;

    logic                    i_clk = 0;
    logic                    i_rst_n = 0;
    logic                    i_in_valid = 0;
    logic                    o_in_ready;
    logic signed [DW-1:0]    i_in_data = '0;
    logic                    i_in_last = 0;
    logic                    o_valid;
    logic                    i_ready = 0;
    logic [CH-1:0][DW-1:0]   o_ia_data;
    logic [CH-1:0][CW-1:0]   o_ia_c_idx;
    logic [LW-1:0]           o_ia_len;

    int checks = 0;
    int errors = 0;

    ia_compressor #(.IA_CHANNEL(CH), .IA_DATA_BITWIDTH(DW), .IA_C_BITWIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_data(i_in_data), .i_in_last(i_in_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_ia_data(o_ia_data), .o_ia_c_idx(o_ia_c_idx), .o_ia_len(o_ia_len)
    );

    always #5 i_clk = ~i_clk;

    // Reference: vector ends at the last-flagged beat or the 8th beat; nonzeros pack from slot 0.
    function automatic void model(input beat_t v[$], output logic [LW-1:0] len,
                                  output logic [CH-1:0][DW-1:0] d, output logic [CH-1:0][CW-1:0] c);
        int n = 0;
        d = '0;
        c = '0;
        for (int i = 0; i < v.size() && i < CH; i++)
            if (v[i] != 0) begin
                d[n] = v[i];
                c[n] = CW'(i);
                n++;
            end
        len = LW'(n);
    endfunction

    function automatic beat_t rand_beat();
        if ($urandom_range(1, 0) == 0) return '0;
        return beat_t'($urandom);
    endfunction

    // Drives all beats (optional idle gaps); early is set if o_valid rose before the final beat.
    task automatic send_vec(input beat_t v[$], input bit use_last, input bit gaps, output bit early);
        early = 0;
        for (int i = 0; i < v.size(); i++) begin
            if (gaps) repeat ($urandom_range(2, 0)) begin
                i_in_valid = 0;
                i_in_data  = rand_beat();
                i_in_last  = 1'($urandom);
                @(posedge i_clk); #1;
                if (o_valid) early = 1;
            end
            i_in_valid = 1;
            i_in_data  = v[i];
            i_in_last  = use_last && (i == v.size() - 1);
            @(posedge i_clk); #1;
            if (o_valid && i != v.size() - 1) early = 1;
        end
        i_in_valid = 0;
        i_in_data  = '0;
        i_in_last  = 0;
    endtask

    task automatic handshake();
        i_ready = 1;
        @(posedge i_clk); #1;
        i_ready = 0;
    endtask

    task automatic test_reset();
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_ia_len !== '0 || o_ia_data !== '0 || o_ia_c_idx !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b len=%0d data=%h idx=%h, need 0/1/0/0/0",
                     o_valid, o_in_ready, o_ia_len, o_ia_data, o_ia_c_idx);
        end
        checks++;
        i_rst_n = 1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_directed_full();
        beat_t v[$] = '{0, 0, 2, 3, 0, 5, 6, 0};
        logic [LW-1:0] el; logic [CH-1:0][DW-1:0] ed; logic [CH-1:0][CW-1:0] ec;
        bit early;
        model(v, el, ed, ec);
        send_vec(v, 0, 0, early);
        checks++;
        if (early || o_valid !== 1'b1) begin
            errors++; $display("FAIL full_latency: early=%b valid=%b, need 0/1", early, o_valid);
        end
        checks++;
        if (o_ia_len !== 4'd4 || o_ia_len !== el) begin
            errors++; $display("FAIL full_len: got %0d need 4", o_ia_len);
        end
        checks++;
        if (o_ia_data !== ed || o_ia_c_idx !== ec) begin
            errors++; $display("FAIL full_slots: data=%h idx=%h need %h %h", o_ia_data, o_ia_c_idx, ed, ec);
        end
        handshake();
        checks++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_ia_len !== '0 || o_ia_data !== '0) begin
            errors++; $display("FAIL full_clear: valid=%b ready=%b len=%0d", o_valid, o_in_ready, o_ia_len);
        end
    endtask

    task automatic test_directed_last();
        beat_t v[$] = '{0, -7, 0, 9};
        beat_t w[$] = '{4, 0};
        logic [LW-1:0] el; logic [CH-1:0][DW-1:0] ed; logic [CH-1:0][CW-1:0] ec;
        bit early;
        send_vec(v, 1, 0, early);
        checks++;
        if (early || o_valid !== 1'b1 || o_ia_len !== 4'd2 || o_ia_data[0] !== 16'hFFF9 ||
            o_ia_data[1] !== 16'd9 || o_ia_c_idx[0] !== 3'd1 || o_ia_c_idx[1] !== 3'd3 ||
            o_ia_data[CH-1:2] !== '0 || o_ia_c_idx[CH-1:2] !== '0) begin
            errors++; $display("FAIL last_vec: valid=%b len=%0d data=%h idx=%h, need len 2 {-7,9} {1,3}",
                               o_valid, o_ia_len, o_ia_data, o_ia_c_idx);
        end
        handshake();
        model(w, el, ed, ec);
        send_vec(w, 1, 0, early);
        checks++;
        if (o_ia_len !== el || o_ia_data !== ed || o_ia_c_idx !== ec) begin
            errors++; $display("FAIL last_restart: len=%0d idx=%h need %0d %h", o_ia_len, o_ia_c_idx, el, ec);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        beat_t v[$];
        logic [LW-1:0] el; logic [CH-1:0][DW-1:0] ed; logic [CH-1:0][CW-1:0] ec;
        bit early, bad;
        for (int i = 0; i < 6; i++) v.push_back(rand_beat());
        model(v, el, ed, ec);
        send_vec(v, 1, 0, early);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            i_in_valid = 1;
            i_in_data  = beat_t'($urandom_range(500, 1));
            i_in_last  = 1'($urandom);
            @(posedge i_clk); #1;
            if (o_valid !== 1'b1 || o_in_ready !== 1'b0 || o_ia_len !== el ||
                o_ia_data !== ed || o_ia_c_idx !== ec) bad = 1;
        end
        i_in_valid = 0; i_in_data = '0; i_in_last = 0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL backpressure_hold: len=%0d data=%h need %0d %h", o_ia_len, o_ia_data, el, ed);
        end
        handshake();
        checks++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: valid=%b ready=%b need 0/1", o_valid, o_in_ready);
        end
    endtask

    task automatic test_boundaries();
        beat_t z[$] = '{0, 0, 0, 0, 0, 0, 0, 0};
        beat_t f[$] = '{1, 2, 3, 4, 5, 6, 7, 8};
        beat_t s[$];
        bit early;
        send_vec(z, 0, 0, early);
        checks++;
        if (o_valid !== 1'b1 || o_ia_len !== '0 || o_ia_data !== '0 || o_ia_c_idx !== '0) begin
            errors++; $display("FAIL zeros: valid=%b len=%0d need 1/0", o_valid, o_ia_len);
        end
        handshake();
        send_vec(f, 0, 0, early);
        checks++;
        if (o_ia_len !== 4'd8 || o_ia_c_idx !== {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0} ||
            o_ia_data[7] !== 16'd8 || o_ia_data[0] !== 16'd1) begin
            errors++; $display("FAIL all_nonzero: len=%0d idx=%h need 8 fac688", o_ia_len, o_ia_c_idx);
        end
        handshake();
        s = '{0};
        send_vec(s, 1, 0, early);
        checks++;
        if (o_valid !== 1'b1 || o_ia_len !== '0) begin
            errors++; $display("FAIL single_zero: valid=%b len=%0d need 1/0", o_valid, o_ia_len);
        end
        handshake();
        s = '{-3};
        send_vec(s, 1, 0, early);
        checks++;
        if (o_valid !== 1'b1 || o_ia_len !== 4'd1 || o_ia_data[0] !== 16'hFFFD || o_ia_c_idx[0] !== 3'd0) begin
            errors++; $display("FAIL single_nz: len=%0d data0=%h need 1 fffd", o_ia_len, o_ia_data[0]);
        end
        handshake();
    endtask

    task automatic test_reset_abort();
        beat_t p[$] = '{5, 6, 7};
        beat_t f[$];
        logic [LW-1:0] el; logic [CH-1:0][DW-1:0] ed; logic [CH-1:0][CW-1:0] ec;
        bit early;
        send_vec(p, 0, 0, early);
        #2 i_rst_n = 0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_ia_len !== '0 || o_ia_data !== '0) begin
            errors++; $display("FAIL rst_collect: valid=%b ready=%b len=%0d need 0/1/0", o_valid, o_in_ready, o_ia_len);
        end
        @(posedge i_clk); #1 i_rst_n = 1;
        for (int i = 0; i < 8; i++) f.push_back(beat_t'($urandom_range(900, 1)));
        send_vec(f, 0, 0, early);
        #2 i_rst_n = 0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_ia_len !== '0 || o_ia_c_idx !== '0) begin
            errors++; $display("FAIL rst_hold: valid=%b ready=%b len=%0d need 0/1/0", o_valid, o_in_ready, o_ia_len);
        end
        @(posedge i_clk); #1 i_rst_n = 1;
        f.delete();
        for (int i = 0; i < 8; i++) f.push_back(rand_beat());
        model(f, el, ed, ec);
        send_vec(f, 0, 0, early);
        checks++;
        if (early || o_valid !== 1'b1 || o_ia_len !== el || o_ia_data !== ed || o_ia_c_idx !== ec) begin
            errors++; $display("FAIL rst_recover: len=%0d idx=%h need %0d %h", o_ia_len, o_ia_c_idx, el, ec);
        end
        handshake();
    endtask

    task automatic test_random();
        beat_t v[$];
        logic [LW-1:0] el; logic [CH-1:0][DW-1:0] ed; logic [CH-1:0][CW-1:0] ec;
        bit early, use_last;
        for (int t = 0; t < 40; t++) begin
            v.delete();
            for (int i = 0; i < int'($urandom_range(CH, 1)); i++) v.push_back(rand_beat());
            use_last = (v.size() < CH) ? 1'b1 : 1'($urandom);
            model(v, el, ed, ec);
            i_ready = 1'($urandom);
            send_vec(v, use_last, 1, early);
            i_ready = 0;
            checks++;
            if (early || o_valid !== 1'b1 || o_in_ready !== 1'b0 || o_ia_len !== el ||
                o_ia_data !== ed || o_ia_c_idx !== ec) begin
                errors++; $display("FAIL random[%0d]: early=%b valid=%b len=%0d data=%h idx=%h need %0d %h %h",
                                   t, early, o_valid, o_ia_len, o_ia_data, o_ia_c_idx, el, ed, ec);
            end
            repeat ($urandom_range(2, 0)) @(posedge i_clk);
            #1 handshake();
        end
    endtask

    task automatic test_back_to_back();
        beat_t v[$];
        logic [LW-1:0] el; logic [CH-1:0][DW-1:0] ed; logic [CH-1:0][CW-1:0] ec;
        bit early;
        for (int t = 0; t < 3; t++) begin
            v.delete();
            for (int i = 0; i < 8; i++) v.push_back(rand_beat());
            model(v, el, ed, ec);
            send_vec(v, 0, 0, early);
            checks++;
            if (o_ia_len !== el || o_ia_data !== ed || o_ia_c_idx !== ec) begin
                errors++; $display("FAIL b2b[%0d]: len=%0d idx=%h need %0d %h", t, o_ia_len, o_ia_c_idx, el, ec);
            end
            handshake();
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_directed_full();
        test_directed_last();
        test_backpressure();
        test_boundaries();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ia_compressor.md
IA_COMPRESSOR -- requirements
Module: ia_compressor

Interface
REQ-001 Parameter IA_CHANNEL, default 32: number of channels per input-activation vector (one pixel).
REQ-002 Parameter IA_DATA_BITWIDTH, default 16: activation data width.
REQ-003 Parameter IA_C_BITWIDTH, default 5: channel-index width. Must satisfy 2^IA_C_BITWIDTH >= IA_CHANNEL.
REQ-004 Port list (name, direction, width, meaning) SHALL be:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_in_valid  in  1  dense channel beat valid.
- o_in_ready  out  1  block can accept a dense beat.
- i_in_data  in  IA_DATA_BITWIDTH signed  dense activation value for the current channel.
- i_in_last  in  1  final channel of this vector; remaining channels are treated as zero.
- o_valid  out  1  compressed IA bundle valid.
- i_ready  in  1  downstream PE loader accepts the bundle.
- o_ia_data  out  IA_CHANNEL x IA_DATA_BITWIDTH signed  nonzero values, packed from slot 0.
- o_ia_c_idx  out  IA_CHANNEL x IA_C_BITWIDTH  channel index of each packed value.
- o_ia_len  out  clog2(IA_CHANNEL)+1  number of valid packed entries.

Function
REQ-005 The block SHALL convert one dense channel vector into the compressed IA bundle consumed by PE (data, c_idx, len).
REQ-006 FSM states SHALL be COLLECT and HOLD; the reset state is COLLECT.
REQ-007 o_in_ready SHALL be 1 exactly when the state is COLLECT.
REQ-008 An input beat is accepted on a rising edge with i_in_valid && o_in_ready. Each accepted beat advances the channel counter ch by 1, starting at 0.
REQ-009 On an accepted beat with i_in_data != 0:
- data is written to slot len;
- ch is written to c_idx slot len;
- len increments.
REQ-010 On an accepted beat with i_in_data == 0, only ch advances; no slot is written.
REQ-011 An accepted beat with ch == IA_CHANNEL-1 or i_in_last == 1 SHALL end the vector. The state becomes HOLD and o_valid = 1 on the next cycle, i.e. 1-cycle latency from the final beat.
REQ-012 In HOLD, o_valid SHALL stay 1 and o_ia_data, o_ia_c_idx and o_ia_len SHALL stay stable until i_ready == 1 is sampled.
REQ-013 On the HOLD handshake (o_valid && i_ready), on that same edge:
- state returns to COLLECT;
- ch, len and all slots clear to 0.
The next input beat can be accepted one cycle later.
REQ-014 Packed slots at index >= o_ia_len SHALL read 0 in both data and c_idx.
REQ-015 An all-zero vector SHALL still be emitted, with o_ia_len = 0.
REQ-016 A vector of all nonzero values SHALL emit o_ia_len = IA_CHANNEL with no overflow. The len width holds the value IA_CHANNEL.
REQ-017 i_in_last on beat 0 SHALL emit a 1-channel vector: o_ia_len is 0 or 1 depending on the value.
REQ-018 Inputs SHALL be ignored while in HOLD (o_in_ready = 0); no state changes.
REQ-019 i_ready while in COLLECT has no effect.
REQ-020 Values are passed through unmodified with their sign preserved; no arithmetic is performed on the data.
REQ-021 o_ia_c_idx values SHALL be strictly increasing over slots 0..len-1.

Reset
REQ-022 When i_rst_n is low, immediately and independent of i_clk:
- state = COLLECT;
- ch = 0, len = 0;
- all slots = 0;
- o_valid = 0, o_in_ready = 1, o_ia_len = 0.
REQ-023 Reset asserted during COLLECT or HOLD SHALL discard the partial or pending vector. After reset release, the next accepted beat is channel 0.
REQ-024 Inputs are not sampled while i_rst_n is low.

Verification
REQ-025 With IA_CHANNEL = 8, send beats {0,0,2,3,0,5,6,0}, i_ready = 1. Required response:
- o_valid high one cycle after the 8th beat;
- o_ia_len = 4;
- o_ia_data[0:3] = {2,3,5,6};
- o_ia_c_idx[0:3] = {2,3,5,6};
- slots 4..7 = 0.
REQ-026 With IA_CHANNEL = 8, send beats {0,-7,0,9} with i_in_last on the 4th beat. Required response: o_ia_len = 2, data = {-7,9}, c_idx = {1,3}; then ch restarts at 0 for the next vector.
REQ-027 Backpressure: hold i_ready = 0 for 5 cycles after o_valid rises. Required response:
- bundle stable and o_in_ready = 0 throughout;
- i_in_valid pulses during HOLD are ignored;
- the handshake on cycle 6 returns the block to COLLECT.
REQ-028 Boundaries with IA_CHANNEL = 8:
- 8 zeros -> o_ia_len = 0;
- 8 nonzero values 1..8 -> o_ia_len = 8, c_idx = {0..7}.
REQ-029 Assert i_rst_n low after 3 beats, and separately during HOLD. Required response: o_valid drops asynchronously. A full vector sent after release emits correct len and indices, with no residue from the aborted vector.
REQ-030 Loopback: drive the outputs into PE's IA bundle with i_ia_iters = 1. PE o_output_feature SHALL match a dense-convolution golden model for the same vector.
